// File: rtl/simplecpu_boot_ctrl_if.sv
// Bundle of loader, CPU, RAM and host/status signals for the boot controller.
//
// Loader handshake: a word transfers on any rising edge where ld_valid and
// ld_ready are both high. The loader holds ld_data/ld_last stable while
// ld_valid is high and ld_ready is low. ld_ready never depends on ld_valid.
interface simplecpu_boot_ctrl_if #(
    parameter int SIZE = 10
);
    logic            start;
    logic            abort;
    logic            ld_valid;
    logic            ld_ready;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic [SIZE-1:0] dbg_addr;
    logic            cpu_rst;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_wdata;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_wdata;
    logic            busy;
    logic            halted;
    logic [SIZE:0]   load_count;
    logic [2:0]      state;      // debug view of the controller FSM

    // Controller side.
    modport slave (
        input  start, abort, ld_valid, ld_data, ld_last, dbg_addr,
               cpu_wrEn, cpu_addr, cpu_wdata,
        output ld_ready, cpu_rst, ram_wrEn, ram_addr, ram_wdata,
               busy, halted, load_count, state
    );

    // Host / loader / CPU / RAM side.
    modport master (
        output start, abort, ld_valid, ld_data, ld_last, dbg_addr,
               cpu_wrEn, cpu_addr, cpu_wdata,
        input  ld_ready, cpu_rst, ram_wrEn, ram_addr, ram_wdata,
               busy, halted, load_count, state
    );
endinterface

// File: rtl/simplecpu_boot_ctrl.sv
// Boot and run controller for SimpleCPU: loads a program image into RAM
// from a streaming loader, holds the CPU in reset during load and for a
// short release window, runs it, and stops it on a write to HALT_ADDR or
// on abort. Owns the RAM port mux (loader / CPU / host).
module simplecpu_boot_ctrl #(
    parameter int          SIZE       = 10,
    parameter int unsigned HALT_ADDR  = (1 << SIZE) - 1,
    parameter int          RST_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    simplecpu_boot_ctrl_if.slave  bus
);

    localparam int               CW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]    REL_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [SIZE-1:0]  HALT_A    = HALT_ADDR[SIZE-1:0];
    localparam logic [SIZE-1:0]  PTR_LAST  = '1;
    localparam logic [SIZE:0]    COUNT_MAX = {1'b1, {SIZE{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t          state;
    logic [SIZE-1:0] ptr;
    logic [CW-1:0]   rel_cnt;
    logic [SIZE:0]   load_count_q;
    logic            cpu_rst_q;
    logic            ld_ready_q;
    logic            busy_q;
    logic            halted_q;

    logic accept;
    logic halt_write;

    // ld_ready_q is only ever high in LOAD, so this is the handshake itself.
    assign accept     = bus.ld_valid & ld_ready_q;
    assign halt_write = bus.cpu_wrEn & (bus.cpu_addr == HALT_A);

    // Controller FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            rel_cnt      <= '0;
            load_count_q <= '0;
            cpu_rst_q    <= 1'b1;
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        state        <= S_LOAD;
                        ptr          <= '0;
                        load_count_q <= '0;
                        ld_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        halted_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        ptr <= ptr + 1'b1;
                        if (load_count_q != COUNT_MAX) begin
                            load_count_q <= load_count_q + 1'b1;
                        end
                        // The top RAM word ends the image: the pointer may not wrap.
                        if (bus.ld_last || ptr == PTR_LAST) begin
                            state      <= S_RELEASE;
                            ld_ready_q <= 1'b0;
                            rel_cnt    <= '0;
                        end
                    end
                end
                S_RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        state     <= S_RUN;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The halt write itself reaches RAM this cycle via the mux.
                    if (bus.abort || halt_write) begin
                        state     <= S_HALT;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        halted_q  <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    cpu_rst_q  <= 1'b1;
                    ld_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux selected by the registered state.
    always_comb begin
        bus.ram_wrEn  = 1'b0;
        bus.ram_addr  = bus.dbg_addr;
        bus.ram_wdata = '0;
        case (state)
            S_LOAD: begin
                bus.ram_wrEn  = accept;
                bus.ram_addr  = ptr;
                bus.ram_wdata = bus.ld_data;
            end
            S_RELEASE, S_RUN: begin
                bus.ram_wrEn  = bus.cpu_wrEn;
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
            end
            default: begin
                bus.ram_wrEn  = 1'b0;
                bus.ram_addr  = bus.dbg_addr;
                bus.ram_wdata = '0;
            end
        endcase
    end

    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.load_count = load_count_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_simplecpu_boot_ctrl.sv
// Directed bench for simplecpu_boot_ctrl with a behavioural synchronous RAM.
module tb_simplecpu_boot_ctrl;

    localparam int SIZE = 10;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] mem [0:(1<<SIZE)-1];
    logic [31:0] rdata;

    simplecpu_boot_ctrl_if #(.SIZE(SIZE)) bus ();

    simplecpu_boot_ctrl #(
        .SIZE       (SIZE),
        .HALT_ADDR  (1023),
        .RST_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (bus.ram_wrEn) mem[bus.ram_addr] <= bus.ram_wdata;
        rdata <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.ld_last   = 1'b0;
        bus.dbg_addr  = 10'd5;
        bus.cpu_wrEn  = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        rst = 1'b0;

        // Reset state.
        tick();
        check("rst_cpu_rst",  bus.cpu_rst, 1);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_wren",     bus.ram_wrEn, 0);
        check("rst_wdata",    bus.ram_wdata, 0);
        check("rst_addr",     bus.ram_addr, 5);
        check("rst_busy",     bus.busy, 0);
        check("rst_halted",   bus.halted, 0);
        check("rst_count",    bus.load_count, 0);
        check("rst_state",    bus.state, ST_IDLE);
        rst = 1'b1;
        tick();
        check("idle_state", bus.state, ST_IDLE);

        // Load 4 words with a gap after word 2.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load_ready", bus.ld_ready, 1);
        check("load_state", bus.state, ST_LOAD);
        check("load_busy",  bus.busy, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.ld_valid = 1'b0;
                #1;
                check("gap_wren", bus.ram_wrEn, 0);
                tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hA0 + i;
            bus.ld_last  = (i == 3);
            #1;
            check("ld_wren",  bus.ram_wrEn, 1);
            check("ld_addr",  bus.ram_addr, i);
            check("ld_wdata", bus.ram_wdata, 32'hA0 + i);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("rel_state",   bus.state, ST_RELEASE);
        check("rel_ready",   bus.ld_ready, 0);
        check("rel_cpu_rst", bus.cpu_rst, 1);
        check("rel_count",   bus.load_count, 4);
        tick();
        check("rel2_cpu_rst", bus.cpu_rst, 1);
        tick();
        check("run_cpu_rst", bus.cpu_rst, 0);
        check("run_state",   bus.state, ST_RUN);
        for (int i = 0; i < 4; i++) check("ram_small", mem[i], 32'hA0 + i);

        // CPU pass-through in RUN, then asynchronous reset mid-RUN.
        bus.cpu_wrEn  = 1'b1;
        bus.cpu_addr  = 10'h010;
        bus.cpu_wdata = 32'h55;
        #1;
        check("cpu_wren",  bus.ram_wrEn, 1);
        check("cpu_addr",  bus.ram_addr, 10'h010);
        check("cpu_wdata", bus.ram_wdata, 32'h55);
        rst = 1'b0;
        #1;
        check("arst_cpu_rst", bus.cpu_rst, 1);
        check("arst_busy",    bus.busy, 0);
        check("arst_wren",    bus.ram_wrEn, 0);
        check("arst_state",   bus.state, ST_IDLE);
        check("arst_addr",    bus.ram_addr, 5);
        bus.cpu_wrEn = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Full 1024-word image with no ld_last.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hB000_0000 | i;
            tick();
        end
        check("full_state", bus.state, ST_RELEASE);
        check("full_count", bus.load_count, 1024);
        bus.ld_data = 32'hDEAD_BEEF;
        #1;
        check("full_extra_ready", bus.ld_ready, 0);
        check("full_extra_wren",  bus.ram_wrEn, 0);
        tick();
        bus.ld_valid = 1'b0;
        tick();
        check("full_run",  bus.state, ST_RUN);
        check("full_ram0", mem[0], 32'hB000_0000);
        check("full_ram1", mem[1023], 32'hB000_03FF);

        // Software halt: write 7 to 0x3FF.
        bus.cpu_wrEn  = 1'b1;
        bus.cpu_addr  = 10'h3FF;
        bus.cpu_wdata = 32'd7;
        #1;
        check("halt_wren", bus.ram_wrEn, 1);
        check("halt_busy_before", bus.halted, 0);
        tick();
        bus.cpu_wrEn = 1'b0;
        check("halt_halted",  bus.halted, 1);
        check("halt_cpu_rst", bus.cpu_rst, 1);
        check("halt_busy",    bus.busy, 0);
        check("halt_state",   bus.state, ST_HALT);
        check("halt_ram",     mem[1023], 7);
        bus.dbg_addr = 10'h3FF;
        #1;
        check("host_addr", bus.ram_addr, 10'h3FF);
        tick();
        check("host_rdata", rdata, 7);

        // Reload from HALT; start/abort ignored in LOAD.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("reload_halted", bus.halted, 0);
        check("reload_count",  bus.load_count, 0);
        check("reload_ready",  bus.ld_ready, 1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("load_ign_state", bus.state, ST_LOAD);
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hC0 + i;
            bus.ld_last  = (i == 1);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("reload_count2", bus.load_count, 2);
        tick();
        tick();
        check("reload_run", bus.state, ST_RUN);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_ign_state", bus.state, ST_RUN);
        check("run_ign_ready", bus.ld_ready, 0);

        // Abort in RUN does not block a concurrent write.
        bus.abort     = 1'b1;
        bus.cpu_wrEn  = 1'b1;
        bus.cpu_addr  = 10'h020;
        bus.cpu_wdata = 32'h99;
        #1;
        check("abort_wren", bus.ram_wrEn, 1);
        tick();
        bus.abort    = 1'b0;
        bus.cpu_wrEn = 1'b0;
        check("abort_state",  bus.state, ST_HALT);
        check("abort_halted", bus.halted, 1);
        check("abort_ram",    mem[32], 32'h99);

        // Simultaneous halt write and abort.
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hE0;
        bus.ld_last  = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("sim_count", bus.load_count, 1);
        tick();
        tick();
        check("sim_run", bus.state, ST_RUN);
        bus.abort     = 1'b1;
        bus.cpu_wrEn  = 1'b1;
        bus.cpu_addr  = 10'h3FF;
        bus.cpu_wdata = 32'h1234;
        tick();
        bus.abort    = 1'b0;
        bus.cpu_wrEn = 1'b0;
        check("sim_state", bus.state, ST_HALT);
        check("sim_ram",   mem[1023], 32'h1234);
        tick();
        check("sim_stay",   bus.state, ST_HALT);
        check("sim_halted", bus.halted, 1);
        check("sim_ram0",   mem[0], 32'hE0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simplecpu_boot_ctrl.md
# simplecpu_boot_ctrl

Boot and run controller for the SimpleCPU core and its single-port RAM. Owns the RAM port mux, loads a program image from a streaming loader interface, holds the CPU in reset while loading, releases it, and detects a software halt (a write to a reserved address) to stop the CPU and return RAM access to the host. Sits between the CPU, the RAM and the host/testbench loader.

## Interface
- SIZE, 10, RAM address width (RAM depth 2^SIZE words of 32 bits)
- HALT_ADDR, 2^SIZE-1, CPU write address that signals program end
- RST_CYCLES, 2, cycles `cpu_rst` stays high after loading, before the CPU runs (min 1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin loading (accepted in IDLE and HALT only)
- abort  in  1  forces RUN to HALT
- ld_valid  in  1  loader word valid
- ld_ready  out  1  controller accepts loader word
- ld_data  in  32  loader word
- ld_last  in  1  qualifies final word of the image
- dbg_addr  in  SIZE  host read address used in IDLE/HALT
- cpu_rst  out  1  active-high synchronous reset to the CPU
- cpu_wrEn  in  1  CPU write enable
- cpu_addr  in  SIZE  CPU address
- cpu_wdata  in  32  CPU write data
- ram_wrEn  out  1  RAM write enable
- ram_addr  out  SIZE  RAM address
- ram_wdata  out  32  RAM write data
- busy  out  1  high in LOAD, RELEASE, RUN
- halted  out  1  high in HALT
- load_count  out  SIZE+1  words written in the last load

RAM read data goes directly from RAM to CPU and host; this block does not touch it. RAM reads are synchronous: address sampled on a clock edge, data valid the following cycle.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, HALT. Reset (rst low) forces IDLE immediately, from any state.
- RAM mux is combinational from state: LOAD -> loader; RELEASE/RUN -> CPU; IDLE/HALT -> host (`ram_addr=dbg_addr`, `ram_wrEn=0`, `ram_wdata=0`).
- IDLE: `cpu_rst=1`, `ld_ready=0`. `start` -> LOAD; write pointer cleared to 0, `load_count` cleared to 0.
- LOAD: `ld_ready=1`, `cpu_rst=1`. On `ld_valid&ld_ready`: `ram_wrEn=1`, `ram_addr=ptr`, `ram_wdata=ld_data`; ptr and `load_count` increment at the edge. Without `ld_valid`: `ram_wrEn=0`. A word accepted with `ld_last=1`, or the word at ptr=2^SIZE-1 (wrap not allowed), -> RELEASE. `start` and `abort` ignored.
- RELEASE: `cpu_rst=1`, `ld_ready=0`, RAM driven by CPU signals. Counter runs RST_CYCLES cycles, then -> RUN.
- RUN: `cpu_rst=0`, RAM driven by CPU (`ram_wrEn=cpu_wrEn`, etc.). A CPU write with `cpu_addr==HALT_ADDR` passes to RAM in that cycle, then -> HALT. `abort` -> HALT; no write is blocked. If both happen in the same cycle, result is the same (HALT). `start` ignored.
- HALT: `cpu_rst=1`, `halted=1`, host read access. `start` -> LOAD and clears `halted`.
- `load_count` saturates at 2^SIZE; holds its value until the next `start`.

## Timing
- Reset values: `cpu_rst=1`, `ld_ready=0`, `ram_wrEn=0`, `ram_wdata=0`, `ram_addr=dbg_addr`, `busy=0`, `halted=0`, `load_count=0`.
- `start` at edge N -> `ld_ready=1` in cycle N+1.
- One word per cycle at full throughput. Last word at edge M -> RELEASE in cycle M+1 -> `cpu_rst` drops at the start of cycle M+1+RST_CYCLES.
- Halt write at edge H -> RAM write commits at H; `halted=1`, `cpu_rst=1` from cycle H+1.
- `ld_ready`, `ram_*`, `cpu_rst` decode from registered state only; the only combinational paths are the CPU/loader input pass-throughs.

## Test plan
- Reset then idle: rst low mid-RUN -> next cycle `cpu_rst=1`, `busy=0`, `ram_wrEn=0`, state IDLE; `dbg_addr=5` -> `ram_addr=5`.
- Load 4 words 0xA0..0xA3, last on 4th, `ld_valid` gapped after word 2 -> RAM[0..3]=0xA0..0xA3, `load_count=4`, no write during the gap, `cpu_rst` low exactly RST_CYCLES+1 cycles after the last word.
- Full image: 1024 words, no `ld_last` -> RELEASE after word at 0x3FF, `load_count=1024`, RAM[0] not overwritten.
- Halt: program writes 7 to 0x3FF -> RAM[0x3FF]=7, `halted=1` next cycle, host reads 7 via `dbg_addr=0x3FF`.
- Abort in RUN and `start` pulsed in RUN/LOAD -> abort gives HALT; the `start` pulses are ignored; `start` from HALT reloads and `load_count` restarts at 0.
- Simultaneous halt write and abort -> single transition to HALT, write committed.
